// File: rtl/serial_parity_checker.sv
// Receive side of the serial parity link: deserializes W-bit LSB-first frames,
// checks the trailing parity bit and keeps a saturating parity-error count.
module serial_parity_checker #(
    parameter int unsigned W   = 3,
    parameter int unsigned ODD = 0,
    parameter int unsigned CW  = 8
) (
    input  logic          C,
    input  logic          R,
    input  logic          D,
    input  logic          FS,
    input  logic          CLR,
    output logic [W-1:0]  Q,
    output logic          VLD,
    output logic          ERR,
    output logic          BUSY,
    output logic [CW-1:0] ERRCNT
);

    localparam int unsigned CntW = $clog2(W + 1);

    typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

    state_e        state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [W:0]    shifted;
    logic [W-1:0]  q_q, q_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic [CW-1:0] errcnt_q, errcnt_d;
    logic          par_exp;
    logic          par_bad;

    // New bits enter at the MSB so the first bit lands in bit 0 after W shifts.
    assign shifted = {D, shreg_q};
    assign cnt_inc = cnt_q + CntW'(1);
    assign par_exp = (^shreg_q) ^ (ODD != 0);
    assign par_bad = (D != par_exp);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        q_d      = q_q;
        vld_d    = 1'b0;
        err_d    = err_q;
        errcnt_d = errcnt_q;

        if (FS) begin
            // Frame start wins in every state, aborting any frame in progress.
            shreg_d = shifted[W:1];
            cnt_d   = CntW'(1);
            state_d = (W == 1) ? StPar : StData;
        end else begin
            case (state_q)
                StIdle: begin
                end
                StData: begin
                    shreg_d = shifted[W:1];
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CntW'(W)) begin
                        state_d = StPar;
                    end
                end
                StPar: begin
                    q_d     = shreg_q;
                    err_d   = par_bad;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (par_bad && (errcnt_q != '1)) begin
                        errcnt_d = errcnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        if (CLR) begin
            errcnt_d = '0;
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shreg_q  <= '0;
            q_q      <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            q_q      <= q_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign Q      = q_q;
    assign VLD    = vld_q;
    assign ERR    = err_q;
    assign BUSY   = (state_q != StIdle);
    assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: three instances cover W=3 even parity,
// a 2-bit saturating error counter, and W=1 odd parity.
module tb_serial_parity_checker;

    logic clk = 1'b0;
    logic rst;

    logic d_a, fs_a, clr_a, vld_a, err_a, busy_a;
    logic [2:0] q_a;
    logic [7:0] errcnt_a;

    logic d_b, fs_b, clr_b, vld_b, err_b, busy_b;
    logic [2:0] q_b;
    logic [1:0] errcnt_b;

    logic d_c, fs_c, clr_c, vld_c, err_c, busy_c;
    logic [0:0] q_c;
    logic [7:0] errcnt_c;

    logic [31:0] o_q, o_errcnt;
    logic o_vld, o_err, o_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_parity_checker #(.W(3), .ODD(0), .CW(8)) u_a (
        .C(clk), .R(rst), .D(d_a), .FS(fs_a), .CLR(clr_a),
        .Q(q_a), .VLD(vld_a), .ERR(err_a), .BUSY(busy_a), .ERRCNT(errcnt_a)
    );

    serial_parity_checker #(.W(3), .ODD(0), .CW(2)) u_b (
        .C(clk), .R(rst), .D(d_b), .FS(fs_b), .CLR(clr_b),
        .Q(q_b), .VLD(vld_b), .ERR(err_b), .BUSY(busy_b), .ERRCNT(errcnt_b)
    );

    serial_parity_checker #(.W(1), .ODD(1), .CW(8)) u_c (
        .C(clk), .R(rst), .D(d_c), .FS(fs_c), .CLR(clr_c),
        .Q(q_c), .VLD(vld_c), .ERR(err_c), .BUSY(busy_c), .ERRCNT(errcnt_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample(input int dut);
        case (dut)
            0: begin
                o_q = 32'(q_a); o_vld = vld_a; o_err = err_a;
                o_busy = busy_a; o_errcnt = 32'(errcnt_a);
            end
            1: begin
                o_q = 32'(q_b); o_vld = vld_b; o_err = err_b;
                o_busy = busy_b; o_errcnt = 32'(errcnt_b);
            end
            default: begin
                o_q = 32'(q_c); o_vld = vld_c; o_err = err_c;
                o_busy = busy_c; o_errcnt = 32'(errcnt_c);
            end
        endcase
    endtask

    task automatic idle_inputs();
        {d_a, fs_a, clr_a} = 3'b000;
        {d_b, fs_b, clr_b} = 3'b000;
        {d_c, fs_c, clr_c} = 3'b000;
    endtask

    // Drive one bit time, then sample 1 time unit after the rising edge.
    task automatic drive(input int dut, input logic fs, input logic d, input logic clr);
        idle_inputs();
        case (dut)
            0: begin fs_a = fs; d_a = d; clr_a = clr; end
            1: begin fs_b = fs; d_b = d; clr_b = clr; end
            default: begin fs_c = fs; d_c = d; clr_c = clr; end
        endcase
        @(posedge clk);
        #1;
        sample(dut);
    endtask

    // bits[0] goes first; returns sampled just after the parity edge.
    task automatic send_frame(input int dut, input int nbits, input logic [2:0] bits,
                              input logic p, input logic clr_on_par);
        for (int i = 0; i < nbits; i++) begin
            drive(dut, (i == 0), bits[i], 1'b0);
            check("busy_in_frame", 32'(o_busy), 32'd1);
            check("no_vld_in_frame", 32'(o_vld), 32'd0);
        end
        drive(dut, 1'b0, p, clr_on_par);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sample(k);
            check("rst_q", o_q, 32'd0);
            check("rst_vld", 32'(o_vld), 32'd0);
            check("rst_err", 32'(o_err), 32'd0);
            check("rst_busy", 32'(o_busy), 32'd0);
            check("rst_errcnt", o_errcnt, 32'd0);
        end
        rst = 1'b0;

        // Good frame 1,0,1 p=0.
        drive(0, 1'b0, 1'b1, 1'b0);
        check("idle_ignores_d", 32'(o_busy), 32'd0);
        send_frame(0, 3, 3'b101, 1'b0, 1'b0);
        check("f1_vld", 32'(o_vld), 32'd1);
        check("f1_q", o_q, 32'h5);
        check("f1_err", 32'(o_err), 32'd0);
        check("f1_errcnt", o_errcnt, 32'd0);
        check("f1_busy_fall", 32'(o_busy), 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0);
        check("f1_vld_one_cycle", 32'(o_vld), 32'd0);
        check("f1_q_hold", o_q, 32'h5);

        // Bad frame 1,1,1 p=0, then good 0,0,0 p=0.
        send_frame(0, 3, 3'b111, 1'b0, 1'b0);
        check("f2_vld", 32'(o_vld), 32'd1);
        check("f2_q", o_q, 32'h7);
        check("f2_err", 32'(o_err), 32'd1);
        check("f2_errcnt", o_errcnt, 32'd1);
        drive(0, 1'b0, 1'b0, 1'b0);
        check("f2_err_hold", 32'(o_err), 32'd1);
        send_frame(0, 3, 3'b000, 1'b0, 1'b0);
        check("f3_q", o_q, 32'h0);
        check("f3_err", 32'(o_err), 32'd0);
        check("f3_errcnt", o_errcnt, 32'd1);

        // Back-to-back: 1,0,0 p=1 then 0,1,1 p=0 with no gap.
        send_frame(0, 3, 3'b001, 1'b1, 1'b0);
        check("b2b1_vld", 32'(o_vld), 32'd1);
        check("b2b1_q", o_q, 32'h1);
        check("b2b1_err", 32'(o_err), 32'd0);
        send_frame(0, 3, 3'b110, 1'b0, 1'b0);
        check("b2b2_vld", 32'(o_vld), 32'd1);
        check("b2b2_q", o_q, 32'h6);
        check("b2b2_err", 32'(o_err), 32'd0);
        check("b2b_errcnt", o_errcnt, 32'd1);

        // Resync: two bits of an aborted frame, then 1,1,0 p=0.
        drive(0, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b1, 1'b0);
        check("abort_busy", 32'(o_busy), 32'd1);
        send_frame(0, 3, 3'b011, 1'b0, 1'b0);
        check("resync_vld", 32'(o_vld), 32'd1);
        check("resync_q", o_q, 32'h3);
        check("resync_err", 32'(o_err), 32'd0);
        check("resync_errcnt", o_errcnt, 32'd1);

        // Asynchronous reset mid-frame.
        drive(0, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        rst = 1'b1;
        #2;
        sample(0);
        check("arst_q", o_q, 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_errcnt", o_errcnt, 32'd0);
        check("arst_vld", 32'(o_vld), 32'd0);
        rst = 1'b0;
        send_frame(0, 3, 3'b010, 1'b1, 1'b0);
        check("post_rst_vld", 32'(o_vld), 32'd1);
        check("post_rst_q", o_q, 32'h2);
        check("post_rst_err", 32'(o_err), 32'd0);

        // CW=2 saturation: 1,0,0 with p=0 is bad.
        for (int n = 1; n <= 5; n++) begin
            send_frame(1, 3, 3'b001, 1'b0, 1'b0);
            check("sat_err", 32'(o_err), 32'd1);
            check("sat_errcnt", o_errcnt, (n < 3) ? 32'(n) : 32'd3);
        end
        send_frame(1, 3, 3'b001, 1'b0, 1'b1);
        check("clr_win_errcnt", o_errcnt, 32'd0);
        check("clr_win_err", 32'(o_err), 32'd1);
        check("clr_win_vld", 32'(o_vld), 32'd1);

        // W=1 odd parity: data 1 expects parity 0.
        send_frame(2, 1, 3'b001, 1'b0, 1'b0);
        check("odd_vld", 32'(o_vld), 32'd1);
        check("odd_q", o_q, 32'd1);
        check("odd_good_err", 32'(o_err), 32'd0);
        check("odd_good_cnt", o_errcnt, 32'd0);
        send_frame(2, 1, 3'b001, 1'b1, 1'b0);
        check("odd_bad_err", 32'(o_err), 32'd1);
        check("odd_bad_cnt", o_errcnt, 32'd1);
        drive(2, 1'b0, 1'b0, 1'b0);
        check("odd_vld_drop", 32'(o_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Receive side of the serial parity link.
- Consumes a serial bit stream framed as W data bits followed by one parity bit. The parity bit is XOR of the frame's data bits, with an optional odd-parity inversion.
- Deserializes each frame into a parallel word, checks its parity, and pulses a valid strobe with an error flag.
- Keeps a saturating error counter for link monitoring.

Parameters:
- W, 3, data bits per frame (W >= 1)
- ODD, 0, 0 = even parity (P = XOR of data), 1 = odd parity (P = ~XOR of data)
- CW, 8, width of error counter

Ports:
- C  input  1  clock; all sampling on rising edge
- R  input  1  reset; asynchronous, active-high
- D  input  1  serial data line
- FS  input  1  frame start; high in the cycle D carries data bit 0
- CLR  input  1  synchronous clear of ERRCNT
- Q  output  W  last received data word; first received bit in Q[0] (LSB-first)
- VLD  output  1  one-cycle pulse: Q/ERR updated for a completed frame
- ERR  output  1  parity mismatch flag of last completed frame
- BUSY  output  1  high while a frame is in progress (state != IDLE)
- ERRCNT  output  CW  count of parity errors, saturating

Behaviour:
- Reset (R high, async): state = IDLE, bit counter = 0, shift register = 0, Q = 0, VLD = 0, ERR = 0, BUSY = 0, ERRCNT = 0. A frame in progress is dropped.
- States: IDLE, DATA, PAR.
- IDLE:
  - D is ignored while FS = 0.
  - Edge with FS = 1: capture D as bit 0 and set bit counter = 1.
  - Next state is DATA, or PAR if W = 1.
- DATA:
  - Each edge captures D as the next bit, counter += 1.
  - When the counter reaches W, next state is PAR.
- PAR:
  - The edge samples D as the parity bit.
  - exp = XOR(data bits) ^ ODD.
  - Q <= data word; ERR <= (D != exp); VLD <= 1 for exactly one cycle.
  - Next state is IDLE.
- Latency: FS sampled at edge k. Data bits are sampled at edges k..k+W-1 and parity at edge k+W. Q/ERR/VLD are valid after edge k+W, with VLD high for that single cycle.
- Q and ERR hold their values until the next completed frame. VLD is 0 otherwise.
- Back-to-back frames: FS = 1 in the cycle right after the parity bit (state IDLE) starts a new frame with zero gap. VLD of the previous frame and capture of the new bit 0 occur on consecutive edges with no interaction.
- Resync: FS = 1 while in DATA or PAR aborts the current frame.
  - No VLD, no ERR change, no ERRCNT change.
  - That same edge captures D as bit 0 of a new frame (counter = 1).
- ERRCNT:
  - Increments on the edge that sets ERR = 1.
  - Saturates at 2^CW - 1, with no wrap.
  - CLR = 1 sets it to 0. CLR wins over a simultaneous increment.
- BUSY = (state != IDLE). BUSY falls after the parity edge.
- All outputs are registered. There is no combinational path from D/FS to any output.

Test Plan:
- W=3, ODD=0. FS with bit 1, then bits 0, 1, parity 0 -> VLD pulse one cycle after the parity edge, Q = 3'b101, ERR = 0, ERRCNT = 0.
- Bits 1, 1, 1, parity 0 -> Q = 3'b111, ERR = 1, ERRCNT = 1. Then a good frame 0, 0, 0, parity 0 -> ERR = 0, ERRCNT stays 1.
- Two back-to-back frames (FS in the cycle after the first parity bit): 1, 0, 0, p=1 then 0, 1, 1, p=0 -> two VLD pulses 4 cycles apart, Q = 3'b001 then 3'b110, ERR = 0 both.
- FS reasserted after 2 data bits, then a full good frame 1, 1, 0, p=0 -> only one VLD, Q = 3'b011, ERRCNT unchanged. Also assert R mid-frame -> all outputs 0 immediately, next FS frame decodes correctly.
- CW=2: five bad frames -> ERRCNT = 1, 2, 3, 3, 3. CLR coincident with a 6th bad frame -> ERRCNT = 0, ERR = 1.
- ODD=1, W=1: FS with bit 1, parity 0 -> ERR = 0. Same frame with parity 1 -> ERR = 1. Check VLD after edge k+1.
